// File: rtl/dram_burst_if.sv
// Request/response bundle for the dram_burst memory front end.
// master drives RD, WR, Addr, DataIn, BurstLen; slave returns DataOut, Valid, Busy, Err.
interface dram_burst_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int BL_W   = 3
);
    logic              RD;
    logic              WR;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] DataIn;
    logic [BL_W-1:0]   BurstLen;
    logic [DATA_W-1:0] DataOut;
    logic              Valid;
    logic              Busy;
    logic              Err;

    modport master (
        output RD, WR, Addr, DataIn, BurstLen,
        input  DataOut, Valid, Busy, Err
    );

    modport slave (
        input  RD, WR, Addr, DataIn, BurstLen,
        output DataOut, Valid, Busy, Err
    );
endinterface

// File: rtl/dram_burst.sv
// Word RAM front end with programmable read latency and wrapping read bursts.
// Ports: Clk1, Reset (async, active high), bus (dram_burst_if.slave).
module dram_burst #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 12,
    parameter int RD_LAT     = 2,
    parameter int BURST_MAX  = 4,
    parameter int BL_W       = 3
) (
    input  logic         Clk1,
    input  logic         Reset,
    dram_burst_if.slave  bus
);
    localparam int CW        = $clog2(BURST_MAX + 1);
    localparam int LW        = 4;
    localparam int WAIT_INIT = (RD_LAT >= 2) ? RD_LAT - 2 : 0;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] BURST = 2'd2;

    logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
    logic [1:0]            state;
    logic [LW-1:0]         lat_cnt;
    logic [CW-1:0]         left;
    logic [DEPTH_LOG2-1:0] ptr;
    logic                  busy;
    logic                  valid;
    logic                  err;
    logic [DATA_W-1:0]     dout;

    logic [CW-1:0]         len;
    logic [DEPTH_LOG2-1:0] word;
    logic                  req;
    logic                  wr_ok;
    logic                  acc;
    logic                  addr_unused;

    assign word        = bus.Addr[DEPTH_LOG2-1:0];
    assign addr_unused = ^bus.Addr;
    assign req         = bus.RD | bus.WR;
    assign wr_ok       = bus.WR & ~busy;
    // A write wins over a simultaneous read; the read is dropped.
    assign acc         = bus.RD & ~bus.WR & ~busy;

    always_comb begin
        len = CW'(bus.BurstLen);
        if (bus.BurstLen == '0)
            len = CW'(1);
        else if (32'(bus.BurstLen) > 32'(BURST_MAX))
            len = CW'(BURST_MAX);
    end

    always_ff @(posedge Clk1) begin
        if (wr_ok)
            mem[word] <= bus.DataIn;
    end

    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
            left    <= '0;
            ptr     <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
            dout    <= '0;
        end else begin
            valid <= 1'b0;
            err   <= (busy & req) | (bus.RD & bus.WR & ~busy);
            case (state)
                IDLE: ;
                WAIT: begin
                    if (lat_cnt == '0)
                        state <= BURST;
                    else
                        lat_cnt <= lat_cnt - 1'b1;
                end
                BURST: begin
                    dout  <= mem[ptr];
                    valid <= 1'b1;
                    ptr   <= ptr + 1'b1;
                    left  <= left - 1'b1;
                    // Busy drops during the last beat so the next
                    // request can be sampled on the following edge.
                    if (left == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // Only reachable outside IDLE on the final beat of a
            // one-beat, one-cycle-latency read, where Busy never rose.
            if (acc) begin
                ptr     <= word;
                left    <= len;
                lat_cnt <= LW'(WAIT_INIT);
                state   <= (RD_LAT == 1) ? BURST : WAIT;
                busy    <= !(RD_LAT == 1 && len == CW'(1));
            end
        end
    end

    assign bus.DataOut = dout;
    assign bus.Valid   = valid;
    assign bus.Busy    = busy;
    assign bus.Err     = err;
endmodule

// File: tb/tb_dram_burst.sv
// Self-checking bench for dram_burst: three instances with read latency 1, 2, 5.
// Directed tests run on the latency-2 instance; the latency sweep uses all three.
module tb_dram_burst;
    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int DL  = 12;
    localparam int BM  = 4;
    localparam int BLW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]    rd = '0;
    logic [2:0]    wr = '0;
    logic [AW-1:0] addr [3];
    logic [DW-1:0] din [3];
    logic [BLW-1:0] bl [3];

    wire [2:0]          valid;
    wire [2:0]          busy;
    wire [2:0]          err;
    wire [2:0][DW-1:0]  dout;

    genvar g;
    for (g = 0; g < 3; g++) begin : gi
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 5;
        dram_burst_if #(.DATA_W(DW), .ADDR_W(AW), .BL_W(BLW)) bus ();
        dram_burst #(
            .DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL),
            .RD_LAT(LAT), .BURST_MAX(BM), .BL_W(BLW)
        ) dut (
            .Clk1(clk),
            .Reset(rst),
            .bus(bus)
        );
        assign bus.RD       = rd[g];
        assign bus.WR       = wr[g];
        assign bus.Addr     = addr[g];
        assign bus.DataIn   = din[g];
        assign bus.BurstLen = bl[g];
        assign dout[g]      = bus.DataOut;
        assign valid[g]     = bus.Valid;
        assign busy[g]      = bus.Busy;
        assign err[g]       = bus.Err;
    end

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] ref_mem [2**DL];
    logic [DW-1:0] exp_dout [3];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 5;
    endfunction

    function automatic int eff_len(input int b);
        if (b == 0) return 1;
        if (b > BM) return BM;
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        for (int i = 0; i < 3; i++) begin
            wr[i]   = 1'b1;
            addr[i] = AW'(a);
            din[i]  = d;
        end
        tick();
        wr = '0;
        ref_mem[DL'(a)] = d;
        check("wr_err", err[1], 1'b0);
    endtask

    // inj: cycle offset at which a write is thrown at the running burst.
    // abort: cycle offset after which Reset is pulsed.
    task automatic do_read(input int idx, input int a, input int b,
                           input int inj, input int abort);
        int lat;
        int n;
        lat = lat_of(idx);
        n   = eff_len(b);
        rd[idx]   = 1'b1;
        addr[idx] = AW'(a);
        bl[idx]   = BLW'(b);
        for (int j = 0; j < lat + n; j++) begin
            if (j == inj) begin
                wr[idx]   = 1'b1;
                addr[idx] = 16'h0010;
                din[idx]  = 16'hDEAD;
            end
            tick();
            rd[idx] = 1'b0;
            wr[idx] = 1'b0;
            if (j >= lat)
                exp_dout[idx] = ref_mem[DL'(a + j - lat)];
            check("rd_valid", valid[idx], (j >= lat));
            check("rd_busy", busy[idx], (j <= lat + n - 2));
            check("rd_err", err[idx], (j == inj));
            check("rd_data", dout[idx], exp_dout[idx]);
            if (j == abort) begin
                rst = 1'b1;
                #1;
                check("abort_valid", valid[idx], 1'b0);
                check("abort_busy", busy[idx], 1'b0);
                check("abort_dout", dout[idx], '0);
                tick();
                rst = 1'b0;
                for (int i = 0; i < 3; i++) exp_dout[i] = '0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    check("post_valid", valid[idx], 1'b0);
                    check("post_busy", busy[idx], 1'b0);
                end
                return;
            end
        end
    endtask

    // RD held high every cycle with random address/length; a read is
    // accepted only once the previous one's latency plus beats elapse.
    task automatic sweep(input int idx);
        int lat;
        int s;
        int n;
        int base;
        int free;
        int a;
        int b;
        bit req;
        bit acc;
        bit ev;
        lat  = lat_of(idx);
        s    = -1000;
        n    = 0;
        base = 0;
        free = 0;
        for (int c = 0; c < 56; c++) begin
            req = (c < 40);
            a   = 'h100 + int'($urandom_range(11, 0));
            b   = int'($urandom_range(7, 2));
            rd[idx]   = req;
            addr[idx] = AW'(a);
            bl[idx]   = BLW'(b);
            acc = req && (c >= free);
            if (acc) begin
                s    = c;
                n    = eff_len(b);
                base = a;
                free = c + lat + n;
            end
            tick();
            ev = (c >= s + lat) && (c <= s + lat + n - 1);
            if (ev)
                exp_dout[idx] = ref_mem[DL'(base + c - s - lat)];
            check("sw_valid", valid[idx], ev);
            check("sw_busy", busy[idx], (c <= s + lat + n - 2));
            check("sw_err", err[idx], (req && !acc));
            check("sw_data", dout[idx], exp_dout[idx]);
        end
        rd[idx] = 1'b0;
    endtask

    int rbase;

    initial begin
        for (int i = 0; i < 3; i++) begin
            addr[i]     = '0;
            din[i]      = '0;
            bl[i]       = '0;
            exp_dout[i] = '0;
        end
        for (int i = 0; i < 2**DL; i++) ref_mem[i] = '0;

        tick();
        tick();
        check("rst_valid", valid[1], 1'b0);
        check("rst_busy", busy[1], 1'b0);
        check("rst_err", err[1], 1'b0);
        check("rst_dout", dout[1], '0);
        rst = 1'b0;
        tick();

        do_write('h10, 16'h1111);
        do_write('h11, 16'h2222);
        do_write('h12, 16'h3333);
        do_write('h13, 16'h4444);
        do_read(1, 'h10, 4, -1, -1);

        do_write('hFFF, 16'hAAAA);
        do_write('h000, 16'hBBBB);
        do_read(1, 'h0FFF, 2, -1, -1);

        do_read(1, 'h10, 4, 1, -1);
        tick();
        do_read(1, 'h10, 1, -1, -1);

        for (int i = 0; i < 3; i++) begin
            rd[i]   = 1'b1;
            wr[i]   = 1'b1;
            addr[i] = 16'h0020;
            din[i]  = 16'h5A5A;
            bl[i]   = 3'd1;
        end
        tick();
        rd = '0;
        wr = '0;
        ref_mem[DL'('h20)] = 16'h5A5A;
        check("rw_err", err[1], 1'b1);
        check("rw_valid", valid[1], 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rw_novalid", valid[1], 1'b0);
            check("rw_errclr", err[1], 1'b0);
        end
        do_read(1, 'h20, 1, -1, -1);

        do_read(1, 'h11, 0, -1, -1);
        do_read(1, 'h10, 7, -1, -1);

        do_read(1, 'h10, 4, -1, 3);
        do_read(1, 'h10, 4, -1, -1);

        for (int t = 0; t < 6; t++) begin
            rbase = int'($urandom_range(16'hFFFF, 0));
            for (int i = 0; i < 4; i++)
                do_write(rbase + i, DW'($urandom));
            do_read(1, rbase, int'($urandom_range(7, 0)), -1, -1);
        end

        for (int i = 0; i < 16; i++)
            do_write('h100 + i, DW'($urandom));
        sweep(0);
        sweep(1);
        sweep(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
